// File: rtl/la_capture_ctrl.sv
// la_capture_ctrl
// Capture controller for the 16-pin logic analyzer peripheral. Decodes
// config packets, divides clk into sample ticks, waits for a mask/value
// trigger, then emits a bounded run of sample packets through a single
// output register and closes the run with one status packet.
// Optional feature macro: LA_TIMESTAMP_EN -- adds an 8-bit per-sample
// timestamp in data[23:16] of sample packets (byte count becomes 2'b11).
module la_capture_ctrl #(
  parameter logic [2:0]       PERIPH_ADDR = 3'd0,
  parameter int unsigned      DIV_W       = 16,
  parameter logic [DIV_W-1:0] DIV_RESET   = DIV_W'(15)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] packet_in,
  input  logic        packet_in_valid,
  input  logic [15:0] pin_vals,
  output logic [31:0] packet_out,
  output logic        packet_out_valid,
  input  logic        packet_out_ready,
  output logic        busy,
  output logic        triggered
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [15:0]      trig_mask_reg;
  logic [15:0]      trig_value_reg;
  logic [15:0]      remaining_reg;
  logic [15:0]      drop_cnt_reg;
  logic             aborted_reg;
  logic             triggered_reg;
  logic             out_valid_reg;
  logic [31:0]      out_pkt_reg;

  logic [15:0]      sync_pins;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi = gi + 1) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      // two-flop synchronizer for one asynchronous pin
      always_ff @(posedge clk) begin
        meta_reg <= pin_vals[gi];
        sync_reg <= meta_reg;
      end
      assign sync_pins[gi] = sync_reg;
    end
  endgenerate

  logic        cfg_hit;
  logic [1:0]  opcode;
  logic [15:0] payload;
  logic        running;
  logic        arm_start;
  logic        abort;
  logic        tick;
  logic        trig_match;
  logic        capture_now;
  logic        slot_free;
  logic [31:0] sample_pkt;
  logic [31:0] status_pkt;
  logic        unused_pkt_bits;

  assign cfg_hit = packet_in_valid && packet_in[28] && (packet_in[31:29] == PERIPH_ADDR);
  assign opcode  = packet_in[23:22];
  assign payload = packet_in[15:0];
  // byte count and reserved data bits carry nothing for config packets
  assign unused_pkt_bits = ^{packet_in[27:24], packet_in[21:16]};

  assign running     = (state_reg == S_ARMED) || (state_reg == S_CAPTURE);
  assign arm_start   = cfg_hit && (opcode == 2'b11) && (payload != 16'h0) && (state_reg == S_IDLE);
  // an arm with N==0 during a run is the abort command; it beats a same-cycle tick
  assign abort       = cfg_hit && (opcode == 2'b11) && (payload == 16'h0) && running;
  assign tick        = running && (div_cnt_reg == div_reg);
  assign trig_match  = ((sync_pins ^ trig_value_reg) & trig_mask_reg) == 16'h0;
  // while ARMED only a matching tick captures; the trigger sample is sample 0
  assign capture_now = tick && !abort && ((state_reg == S_CAPTURE) || trig_match);
  // the slot can take a new packet if empty or being drained this cycle
  assign slot_free   = !out_valid_reg || packet_out_ready;

  // sample divider: restarts on arm, wraps on tick, frozen outside a run
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_reg <= '0;
    end else if (arm_start || tick) begin
      div_cnt_reg <= '0;
    end else if (running) begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

`ifdef LA_TIMESTAMP_EN
  logic [7:0] ts_reg;
  logic [7:0] sample_ts;

  // trigger sample is stamped 0, each later capture tick adds one (wraps at 255)
  assign sample_ts = (state_reg == S_ARMED) ? 8'h00 : ts_reg + 8'h01;

  // ts_reg holds the timestamp of the most recently captured sample
  always_ff @(posedge clk) begin
    if (!rst) begin
      ts_reg <= 8'h00;
    end else if (capture_now) begin
      ts_reg <= sample_ts;
    end
  end

  assign sample_pkt = {PERIPH_ADDR, 1'b0, 2'b11, 2'b00, sample_ts, sync_pins};
`else
  assign sample_pkt = {PERIPH_ADDR, 1'b0, 2'b10, 2'b00, 8'h00, sync_pins};
`endif

  assign status_pkt = {PERIPH_ADDR, 1'b1, 2'b11, 2'b00,
                       (aborted_reg ? 8'hDA : 8'hD0), drop_cnt_reg};

  // control FSM with config registers, drop counter and the output slot
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      div_reg        <= DIV_RESET;
      trig_mask_reg  <= 16'h0;
      trig_value_reg <= 16'h0;
      remaining_reg  <= 16'h0;
      drop_cnt_reg   <= 16'h0;
      aborted_reg    <= 1'b0;
      triggered_reg  <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_pkt_reg    <= 32'h0;
    end else begin
      // an accepted packet empties the slot unless something reloads it below
      if (out_valid_reg && packet_out_ready) begin
        out_valid_reg <= 1'b0;
      end

      case (state_reg)
        S_IDLE: begin
          if (cfg_hit) begin
            case (opcode)
              2'b00: div_reg        <= payload[DIV_W-1:0];
              2'b01: trig_mask_reg  <= payload;
              2'b10: trig_value_reg <= payload;
              default: begin
                if (payload != 16'h0) begin
                  state_reg     <= S_ARMED;
                  remaining_reg <= payload;
                  drop_cnt_reg  <= 16'h0;
                  aborted_reg   <= 1'b0;
                  triggered_reg <= 1'b0;
                end
              end
            endcase
          end
        end

        S_ARMED, S_CAPTURE: begin
          if (abort) begin
            state_reg   <= S_DONE;
            aborted_reg <= 1'b1;
          end else if (capture_now) begin
            if (slot_free) begin
              out_pkt_reg   <= sample_pkt;
              out_valid_reg <= 1'b1;
            end else if (drop_cnt_reg != 16'hFFFF) begin
              drop_cnt_reg <= drop_cnt_reg + 16'h1;
            end
            remaining_reg <= remaining_reg - 16'h1;
            triggered_reg <= 1'b1;
            state_reg     <= (remaining_reg == 16'h1) ? S_DONE : S_CAPTURE;
          end
        end

        S_DONE: begin
          if (slot_free) begin
            out_pkt_reg   <= status_pkt;
            out_valid_reg <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign packet_out       = out_pkt_reg;
  assign packet_out_valid = out_valid_reg;
  assign busy             = (state_reg != S_IDLE);
  assign triggered        = triggered_reg;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// tb_la_capture_ctrl
// Directed plus randomized bench for la_capture_ctrl. A transaction-level
// reference model predicts the output slot, busy and triggered every cycle
// from the capture rules: tick edges are computed as arm_edge + k*(div+1),
// the sampled value is the pin value driven two edges earlier.
`timescale 1ns/1ps
module tb_la_capture_ctrl;
  localparam logic [2:0] ADDR = 3'd0;

  logic        clk;
  logic        rst;
  logic [31:0] packet_in;
  logic        packet_in_valid;
  logic [15:0] pin_vals;
  logic [31:0] packet_out;
  logic        packet_out_valid;
  logic        packet_out_ready;
  logic        busy;
  logic        triggered;

  la_capture_ctrl #(
    .PERIPH_ADDR(ADDR),
    .DIV_W      (16),
    .DIV_RESET  (16'd15)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .packet_in       (packet_in),
    .packet_in_valid (packet_in_valid),
    .pin_vals        (pin_vals),
    .packet_out      (packet_out),
    .packet_out_valid(packet_out_valid),
    .packet_out_ready(packet_out_ready),
    .busy            (busy),
    .triggered       (triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] pin_hist [0:65535];
  logic [15:0] pin_and    = 16'hFFFF;
  logic [15:0] pin_or     = 16'h0000;
  bit          rand_ready = 1'b0;

  // reference model state
  int          m_phase     = 0;   // 0 idle, 1 waiting for trigger, 2 capturing, 3 closing
  int          m_div       = 15;
  logic [15:0] m_mask      = 16'h0;
  logic [15:0] m_val       = 16'h0;
  int          m_next_tick = 0;
  int          m_n         = 0;
  int          m_left      = 0;
  int          m_drops     = 0;
  bit          m_abort     = 1'b0;
  bit          m_trig      = 1'b0;
  bit          m_valid     = 1'b0;
  logic [31:0] m_pkt       = 32'h0;
  bit          m_was_reset = 1'b0;

  // observed transfers
  int          samples_seen = 0;
  logic [31:0] last_status  = 32'h0;
  logic [31:0] sample_log [0:255];

  function automatic logic [31:0] cfg_pkt(input logic [1:0] op, input logic [15:0] pay);
    return {ADDR, 1'b1, 2'b11, 2'b00, op, 6'h00, pay};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rn, input bit v, input logic [31:0] p, input bit rdy);
    bit          hit;
    bit          free;
    bit          is_tick;
    bit          fire;
    logic [1:0]  op;
    logic [15:0] pay;
    logic [15:0] s;
    logic [31:0] spkt;
`ifdef LA_TIMESTAMP_EN
    logic [7:0]  ts;
`endif
    m_was_reset = !rn;
    if (!rn) begin
      m_phase = 0; m_div = 15; m_mask = 16'h0; m_val = 16'h0;
      m_left = 0; m_drops = 0; m_abort = 1'b0; m_trig = 1'b0;
      m_valid = 1'b0; m_pkt = 32'h0;
      return;
    end
    free = !m_valid || rdy;
    if (m_valid && rdy) m_valid = 1'b0;
    hit = v && p[28] && (p[31:29] == ADDR);
    op  = p[23:22];
    pay = p[15:0];
    s   = (cyc >= 2) ? pin_hist[cyc-2] : 16'h0;
    is_tick = (m_phase == 1 || m_phase == 2) && (cyc == m_next_tick);
    case (m_phase)
      0: begin
        if (hit) begin
          if (op == 2'b00) m_div = int'(pay);
          else if (op == 2'b01) m_mask = pay;
          else if (op == 2'b10) m_val = pay;
          else if (pay != 16'h0) begin
            m_phase = 1; m_n = int'(pay); m_left = int'(pay); m_drops = 0;
            m_trig = 1'b0; m_abort = 1'b0; m_next_tick = cyc + m_div + 1;
          end
        end
      end
      1, 2: begin
        if (hit && op == 2'b11 && pay == 16'h0) begin
          m_phase = 3; m_abort = 1'b1;
        end else if (is_tick) begin
          m_next_tick = m_next_tick + m_div + 1;
          fire = (m_phase == 2) || (((s ^ m_val) & m_mask) == 16'h0);
          if (fire) begin
`ifdef LA_TIMESTAMP_EN
            ts   = 8'(m_n - m_left);
            spkt = {ADDR, 1'b0, 2'b11, 2'b00, ts, s};
`else
            spkt = {ADDR, 1'b0, 2'b10, 2'b00, 8'h00, s};
`endif
            if (free) begin m_valid = 1'b1; m_pkt = spkt; end
            else if (m_drops < 65535) m_drops++;
            m_left--;
            m_trig  = 1'b1;
            m_phase = (m_left == 0) ? 3 : 2;
          end
        end
      end
      default: begin
        if (free) begin
          m_valid = 1'b1;
          m_pkt   = {ADDR, 1'b1, 2'b11, 2'b00, (m_abort ? 8'hDA : 8'hD0), 16'(m_drops)};
          m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic step(input bit v, input logic [31:0] p);
    bit rdy;
    pin_vals = (16'($urandom()) & pin_and) | pin_or;
    if (rand_ready) packet_out_ready = ($urandom_range(0, 3) != 0);
    packet_in_valid = v;
    packet_in       = p;
    pin_hist[cyc]   = pin_vals;
    rdy             = packet_out_ready;
    if (rst && packet_out_valid && packet_out_ready) begin
      $display("xfer cyc=%0d pkt=%08h", cyc, packet_out);
      if (packet_out[28]) last_status = packet_out;
      else begin
        if (samples_seen < 256) sample_log[samples_seen] = packet_out;
        samples_seen++;
      end
    end
    @(posedge clk);
    model_edge(rst, v, p, rdy);
    cyc++;
    @(negedge clk);
    packet_in_valid = 1'b0;
    packet_in       = 32'h0;
    check("valid", 32'(packet_out_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("triggered", 32'(triggered), 32'(m_trig));
    if (m_valid || m_was_reset) check("packet", packet_out, m_pkt);
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] pay);
    step(1'b1, cfg_pkt(op, pay));
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((m_phase != 0 || m_valid) && n < budget) begin
      step(1'b0, 32'h0);
      n++;
    end
    checks++;
    assert (n < budget) else begin
      failures++;
      $error("FAIL %s: got %0d cycles expected fewer than %0d", tag, n, budget);
    end
  endtask

  // arm with mask 0 and measure edges until the first sample appears
  task automatic arm_and_time(input logic [15:0] nsamp, input int exp_lat, input string tag);
    int n;
    send(2'b11, nsamp);
    n = 0;
    while (!packet_out_valid && n < 200) begin
      step(1'b0, 32'h0);
      n++;
    end
    check(tag, n, exp_lat);
  endtask

  initial begin
    int n;
    rst              = 1'b0;
    packet_in        = 32'h0;
    packet_in_valid  = 1'b0;
    pin_vals         = 16'h0;
    packet_out_ready = 1'b1;

    // reset state
    repeat (3) step(1'b0, 32'h0);
    check("rst_valid", 32'(packet_out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_trig", 32'(triggered), 32'h0);
    check("rst_pkt", packet_out, 32'h0);
    rst = 1'b1;
    step(1'b0, 32'h0);

    // basic run: mask 0, div 15, N=4, always ready
    samples_seen = 0;
    send(2'b11, 16'd4);
    run_until_idle(400, "t1_timeout");
    check("t1_samples", samples_seen, 4);
    check("t1_status", last_status, {ADDR, 1'b1, 2'b11, 2'b00, 8'hD0, 16'h0000});
    check("t1_bytecount", 32'(sample_log[0][27:26]),
`ifdef LA_TIMESTAMP_EN
          32'h3);
`else
          32'h2);
`endif
    check("t1_busy", 32'(busy), 32'h0);

    // trigger on pin0 high
    send(2'b01, 16'h0001);
    send(2'b10, 16'h0001);
    send(2'b00, 16'd3);
    pin_and = 16'hFFFE;
    samples_seen = 0;
    send(2'b11, 16'd2);
    repeat (40) step(1'b0, 32'h0);
    check("t2_quiet", samples_seen, 0);
    check("t2_not_trig", 32'(triggered), 32'h0);
    pin_and = 16'hFFFF;
    pin_or  = 16'h0001;
    run_until_idle(200, "t2_timeout");
    pin_or  = 16'h0000;
    check("t2_samples", samples_seen, 2);
    check("t2_bit0", 32'(sample_log[0][0]), 32'h1);
    check("t2_trig", 32'(triggered), 32'h1);

    // back-pressure: div 0, N=8, ready low for 10 edges
    send(2'b01, 16'h0000);
    send(2'b00, 16'd0);
    samples_seen = 0;
    packet_out_ready = 1'b0;
    send(2'b11, 16'd8);
    repeat (9) step(1'b0, 32'h0);
    packet_out_ready = 1'b1;
    run_until_idle(100, "t3_timeout");
    check("t3_drops", 32'(last_status[15:0]), 32'h7);
    check("t3_code", 32'(last_status[23:16]), 32'hD0);
    check("t3_samples", samples_seen, 1);

    // abort after 3 samples; set-div while busy must not stick
    send(2'b00, 16'd2);
    samples_seen = 0;
    send(2'b11, 16'd100);
    send(2'b00, 16'd7);
    n = 0;
    while (samples_seen < 3 && n < 200) begin
      step(1'b0, 32'h0);
      n++;
    end
    check("t4_wait", samples_seen, 3);
    send(2'b11, 16'd0);
    run_until_idle(100, "t4_timeout");
    check("t4_code", 32'(last_status[23:16]), 32'hDA);
    check("t4_samples", samples_seen, 3);
    samples_seen = 0;
    arm_and_time(16'd2, 3, "t4_period");
    run_until_idle(100, "t4b_timeout");
    check("t4b_samples", samples_seen, 2);

    // foreign address / non-config packets are ignored
    step(1'b1, {3'd1, 1'b1, 2'b11, 2'b00, 2'b00, 6'h00, 16'd5});
    step(1'b1, {ADDR, 1'b0, 2'b11, 2'b00, 2'b00, 6'h00, 16'd5});
    step(1'b1, {3'd5, 1'b1, 2'b11, 2'b00, 2'b01, 6'h00, 16'hFFFF});
    step(1'b1, {3'd2, 1'b1, 2'b11, 2'b00, 2'b11, 6'h00, 16'd5});
    check("t5_no_arm", 32'(busy), 32'h0);
    arm_and_time(16'd50, 3, "t5_cfg_ignored");
    repeat (4) step(1'b0, 32'h0);
    check("t5_busy_mid", 32'(busy), 32'h1);
    rst = 1'b0;
    step(1'b0, 32'h0);
    check("t5_rst_valid", 32'(packet_out_valid), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    samples_seen = 0;
    arm_and_time(16'd2, 16, "t5_div_reset");
    run_until_idle(200, "t5_timeout");
    check("t5_samples", samples_seen, 2);

    // N=3 sample stamping
    samples_seen = 0;
    send(2'b11, 16'd3);
    run_until_idle(200, "t6_timeout");
    check("t6_samples", samples_seen, 3);
    for (int i = 0; i < 3; i++) begin
`ifdef LA_TIMESTAMP_EN
      check("t6_ts", 32'(sample_log[i][23:16]), 32'(i));
      check("t6_bc", 32'(sample_log[i][27:26]), 32'h3);
`else
      check("t6_ts", 32'(sample_log[i][23:16]), 32'h0);
      check("t6_bc", 32'(sample_log[i][27:26]), 32'h2);
`endif
    end

    // randomized runs against the model
    rand_ready = 1'b1;
    for (int r = 0; r < 12; r++) begin
      send(2'b00, 16'($urandom_range(0, 4)));
      send(2'b01, (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15)));
      send(2'b10, 16'($urandom()));
      send(2'b11, 16'($urandom_range(1, 6)));
      run_until_idle(3000, "t7_timeout");
    end
    rand_ready = 1'b0;
    packet_out_ready = 1'b1;
    step(1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
